interboard_receiver: RTL and testbench
======================================

# interboard_receiver

Responder end of the inter-board Request/Ack link: receives two-word messages from the peer board over `Request_in`/`inter_data_in`, acknowledges each word with a four-phase handshake on `Ack_out`, and presents each completed message to the game controller as a one-cycle `interboard_en` pulse with `interboard_msg_type`/`interboard_number`. It sits inside the inter-board communication top, beside the transmitter, and feeds the game FSM and the display reset.

## Interface
- `SYNC_STAGES`, 2: flops on `Request_in` before use (≥2).
- `TIMEOUT_CYCLES`, 1_000_000: watchdog limit in cycles; used only with `INTER_RX_TIMEOUT_EN`.

- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `Request_in` input 1: peer request, asynchronous to `clk`.
- `inter_data_in` input 6: peer data word, stable while `Request_in` is high.
- `Ack_out` output 1: acknowledge to peer.
- `interboard_en` output 1: one-cycle pulse, message valid.
- `interboard_msg_type` output 3: message type, held until next message.
- `interboard_number` output 5: message number, held until next message.
- `interboard_rst` output 1: one-cycle pulse when a MSG_RESET message completes.
- `rx_busy` output 1: high whenever FSM is not in IDLE.
- `rx_error` output 1: one-cycle pulse on framing error or timeout.

## Operation
- Word format: bit5 = word index. Word0 `{0, msg_type[2:0], number[4:3]}`; word1 `{1, 2'b00, number[2:0]}`. Word1 bits[4:3] are ignored.
- `req_s` = `Request_in` after `SYNC_STAGES` flops. Data is sampled in the cycle `req_s` is first seen high. No extra synchronizer on data; the protocol guarantees stability.
- FSM states:
  - IDLE: on `req_s`=1, sample the word.
    - bit5=0: store msg_type/number[4:3], go to ACK0.
    - bit5=1: pulse `rx_error`, go to ACKX (acknowledge and discard).
  - ACK0: `Ack_out`=1. When `req_s`=0, go to WAIT1.
  - WAIT1: `Ack_out`=0. On `req_s`=1, sample the word.
    - bit5=1: store number[2:0], go to ACK1.
    - bit5=0: pulse `rx_error`, treat the word as a new word0 (store it), go to ACK0.
  - ACK1: `Ack_out`=1. When `req_s`=0, go to IDLE, drive outputs, pulse `interboard_en`.
  - ACKX: `Ack_out`=1. When `req_s`=0, go to IDLE.
- Message completion: on the ACK1→IDLE transition, update `interboard_msg_type`/`interboard_number` and pulse `interboard_en`. Also pulse `interboard_rst` if msg_type==MSG_RESET.
- `Ack_out` is registered and decoded from state; there is no combinational path from `Request_in`.
- Reset (any state, asynchronous): state=IDLE, `Ack_out`=0, `interboard_en`=0, `interboard_rst`=0, `rx_error`=0, `rx_busy`=0, `interboard_msg_type`=0, `interboard_number`=0. Any partial message is lost. If the peer is mid-handshake when reset releases, a high `req_s` is processed as a fresh word.

## Timing
- `Request_in` rising at edge t: data sampled at edge t+`SYNC_STAGES`; `Ack_out` high from edge t+`SYNC_STAGES`+1.
- `Request_in` falling at edge u: `Ack_out` low from edge u+`SYNC_STAGES`+1.
- `interboard_en` is high for the single cycle starting at the edge where `Ack_out` falls for word1. `interboard_msg_type`/`interboard_number` are valid in that same cycle.
- Throughput is bounded by the peer; there is no backpressure beyond `Ack_out`.

## Configuration
- `INTER_RX_TIMEOUT_EN` defined: a counter runs in ACK0, WAIT1, ACK1 and ACKX, and clears on every state change. At `TIMEOUT_CYCLES` it pulses `rx_error`, forces IDLE, drops `Ack_out`, and discards the partial message.
- Not defined: no counter; the FSM waits indefinitely in any state.

## Structure
- Shared package `interboard_pkg`: msg_type constants MSG_RESET=3'd0, MSG_NUMBER=3'd1, MSG_BINGO=3'd2, MSG_START=3'd3; word-index bit position; word field widths.
- One sub-module: `sync_2ff` (parameterized depth), used for `Request_in`. The transmitter reuses it for `Ack_in`.

## Test plan
- Send word0=6'b0_001_10, then word1=6'b1_00_101 with a well-behaved peer. Required: `interboard_msg_type`=1, `interboard_number`=5'b10101=21, one `interboard_en` pulse, no `interboard_rst`, `Ack_out` edges at the stated latencies.
- Send MSG_RESET with number 0. Required: `interboard_en` and `interboard_rst` pulse in the same cycle.
- Send word1 (bit5=1) first. Required: `rx_error` pulse, word acknowledged, no `interboard_en`. A following valid message decodes correctly.
- Send word0 (type 2, num[4:3]=3), then word0 again (type 1, num[4:3]=0), then word1 (num[2:0]=7). Required: one `rx_error` pulse, then `interboard_msg_type`=1, `interboard_number`=7.
- Assert `rst` low while in ACK1. Required: `Ack_out`=0 and all outputs 0 immediately; no `interboard_en`.
- With `INTER_RX_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send word0, then hold `Request_in` low. Required: `rx_error` pulses 100 cycles after entering WAIT1, FSM returns to IDLE, `rx_busy`=0.

Source files
------------

// File: rtl/interboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interboard_pkg
// Description : Shared message constants, word layout and decoded-message
//               type for the inter-board Request/Ack link.
// Revision    : 1.0 - initial release
// ============================================================================
package interboard_pkg;

   localparam int c_word_w   = 6;
   localparam int c_idx_bit  = 5;
   localparam int c_type_w   = 3;
   localparam int c_num_w    = 5;
   localparam int c_num_hi_w = 2;
   localparam int c_num_lo_w = 3;

   localparam logic [c_type_w-1:0] MSG_RESET  = 3'd0;
   localparam logic [c_type_w-1:0] MSG_NUMBER = 3'd1;
   localparam logic [c_type_w-1:0] MSG_BINGO  = 3'd2;
   localparam logic [c_type_w-1:0] MSG_START  = 3'd3;

   typedef struct packed {
      logic [c_type_w-1:0] msg_type;
      logic [c_num_w-1:0]  number;
   } msg_t;

   function automatic logic is_word1(input logic [c_word_w-1:0] w);
      return w[c_idx_bit];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Multi-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/interboard_receiver.sv
`default_nettype none
// ============================================================================
// Module      : interboard_receiver
// Description : Responder end of the inter-board Request/Ack link; assembles
//               two-word messages and pulses them out to the game controller.
//               Optional watchdog enabled by defining INTER_RX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module interboard_receiver
   import interboard_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                Request_in,
   input  logic [c_word_w-1:0] inter_data_in,
   output logic                Ack_out,
   output logic                interboard_en,
   output logic [c_type_w-1:0] interboard_msg_type,
   output logic [c_num_w-1:0]  interboard_number,
   output logic                interboard_rst,
   output logic                rx_busy,
   output logic                rx_error
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_ack0  = 3'd1;
   localparam logic [2:0] c_st_wait1 = 3'd2;
   localparam logic [2:0] c_st_ack1  = 3'd3;
   localparam logic [2:0] c_st_ackx  = 3'd4;

   logic                  w_req_s;
   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic                  w_ld_w0;
   logic                  w_ld_w1;
   logic                  w_complete;
   logic                  w_err;
   logic                  w_ack_nxt;
   logic                  w_timeout;
   logic [c_type_w-1:0]   r_type;
   logic [c_num_hi_w-1:0] r_num_hi;
   logic [c_num_lo_w-1:0] r_num_lo;
   msg_t                  r_done_msg;
   logic                  r_done;

   sync_2ff #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (Request_in),
      .q   (w_req_s)
   );

`ifdef INTER_RX_TIMEOUT_EN
   localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [c_cnt_w-1:0] r_cnt;

   // Counts cycles spent in the current non-idle state; restarts on any move.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if ((r_state == c_st_idle) || (w_state_nxt != r_state)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state != c_st_idle) && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_w0     = 1'b0;
      w_ld_w1     = 1'b0;
      w_complete  = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (w_req_s) begin
               if (is_word1(inter_data_in)) begin
                  w_err       = 1'b1;
                  w_state_nxt = c_st_ackx;
               end else begin
                  w_ld_w0     = 1'b1;
                  w_state_nxt = c_st_ack0;
               end
            end
         end
         c_st_ack0: begin
            if (!w_req_s) w_state_nxt = c_st_wait1;
         end
         c_st_wait1: begin
            if (w_req_s) begin
               if (is_word1(inter_data_in)) begin
                  w_ld_w1     = 1'b1;
                  w_state_nxt = c_st_ack1;
               end else begin
                  // A repeated word0 restarts the message rather than being dropped.
                  w_err       = 1'b1;
                  w_ld_w0     = 1'b1;
                  w_state_nxt = c_st_ack0;
               end
            end
         end
         c_st_ack1: begin
            if (!w_req_s) begin
               w_complete  = 1'b1;
               w_state_nxt = c_st_idle;
            end
         end
         c_st_ackx: begin
            if (!w_req_s) w_state_nxt = c_st_idle;
         end
         default: w_state_nxt = c_st_idle;
      endcase
      if (w_timeout) begin
         w_state_nxt = c_st_idle;
         w_err       = 1'b1;
         w_ld_w0     = 1'b0;
         w_ld_w1     = 1'b0;
         w_complete  = 1'b0;
      end
   end

   always_comb begin
      w_ack_nxt = (r_state == c_st_ack0) || (r_state == c_st_ack1) || (r_state == c_st_ackx);
   end

   // Finished message is staged so the output stage lines up with the Ack fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_type     <= '0;
         r_num_hi   <= '0;
         r_num_lo   <= '0;
         r_done     <= 1'b0;
         r_done_msg <= '0;
      end else begin
         if (w_ld_w0) begin
            r_type   <= inter_data_in[c_idx_bit-1 -: c_type_w];
            r_num_hi <= inter_data_in[c_num_hi_w-1:0];
         end
         if (w_ld_w1) begin
            r_num_lo <= inter_data_in[c_num_lo_w-1:0];
         end
         r_done <= w_complete;
         if (w_complete) begin
            r_done_msg.msg_type <= r_type;
            r_done_msg.number   <= {r_num_hi, r_num_lo};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Ack_out             <= 1'b0;
         interboard_en       <= 1'b0;
         interboard_rst      <= 1'b0;
         rx_error            <= 1'b0;
         interboard_msg_type <= '0;
         interboard_number   <= '0;
      end else begin
         Ack_out        <= w_ack_nxt;
         interboard_en  <= r_done;
         interboard_rst <= r_done && (r_done_msg.msg_type == MSG_RESET);
         rx_error       <= w_err;
         if (r_done) begin
            interboard_msg_type <= r_done_msg.msg_type;
            interboard_number   <= r_done_msg.number;
         end
      end
   end

   assign rx_busy = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_interboard_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_interboard_receiver
// Description : Directed, table-driven bench for interboard_receiver with a
//               well-behaved peer model; covers INTER_RX_TIMEOUT_EN when set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interboard_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       Request_in = 1'b0;
   logic [5:0] inter_data_in = '0;
   logic       Ack_out;
   logic       interboard_en;
   logic [2:0] interboard_msg_type;
   logic [4:0] interboard_number;
   logic       interboard_rst;
   logic       rx_busy;
   logic       rx_error;

   interboard_receiver #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .Request_in          (Request_in),
      .inter_data_in       (inter_data_in),
      .Ack_out             (Ack_out),
      .interboard_en       (interboard_en),
      .interboard_msg_type (interboard_msg_type),
      .interboard_number   (interboard_number),
      .interboard_rst      (interboard_rst),
      .rx_busy             (rx_busy),
      .rx_error            (rx_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         en_cnt = 0, rstp_cnt = 0, err_cnt = 0;
   int         en_cyc = -1, rstp_cyc = -1, err_cyc = -1;
   logic [2:0] cap_type = '0;
   logic [4:0] cap_num = '0;

   always @(negedge clk) begin
      if (interboard_en) begin
         en_cnt   = en_cnt + 1;
         en_cyc   = cyc;
         cap_type = interboard_msg_type;
         cap_num  = interboard_number;
      end
      if (interboard_rst) begin
         rstp_cnt = rstp_cnt + 1;
         rstp_cyc = cyc;
      end
      if (rx_error) begin
         err_cnt = err_cnt + 1;
         err_cyc = cyc;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Peer: raise Request with data, wait for Ack, drop Request, wait for Ack low.
   task automatic send_word(input logic [5:0] w, input string tag, output int fc);
      int t, u, rl, fl;
      @(posedge clk); #1;
      Request_in    = 1'b1;
      inter_data_in = w;
      t  = cyc + 1;
      rl = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (Ack_out) begin
            rl = cyc - t;
            break;
         end
      end
      @(posedge clk); #1;
      Request_in = 1'b0;
      u  = cyc + 1;
      fl = -1;
      fc = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!Ack_out) begin
            fl = cyc - u;
            fc = cyc;
            break;
         end
      end
      chk({tag, "_ack_rise_lat"}, rl, 3);
      chk({tag, "_ack_fall_lat"}, fl, 3);
   endtask

   typedef struct {
      logic [5:0] w0;
      logic [5:0] w1;
      int         exp_type;
      int         exp_num;
      int         exp_rst;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int e0, r0, x0, fc;

      vecs[0] = '{w0: 6'b0_001_10, w1: 6'b1_00_101, exp_type: 1, exp_num: 21, exp_rst: 0};
      vecs[1] = '{w0: 6'b0_000_00, w1: 6'b1_00_000, exp_type: 0, exp_num: 0,  exp_rst: 1};
      vecs[2] = '{w0: 6'b0_011_11, w1: 6'b1_11_111, exp_type: 3, exp_num: 31, exp_rst: 0};
      vecs[3] = '{w0: 6'b0_010_01, w1: 6'b1_00_010, exp_type: 2, exp_num: 10, exp_rst: 0};

      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack", int'(Ack_out), 0);
      chk("reset_en", int'(interboard_en), 0);
      chk("reset_irst", int'(interboard_rst), 0);
      chk("reset_err", int'(rx_error), 0);
      chk("reset_busy", int'(rx_busy), 0);
      chk("reset_type", int'(interboard_msg_type), 0);
      chk("reset_num", int'(interboard_number), 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_busy", int'(rx_busy), 0);

      for (int i = 0; i < 4; i++) begin
         e0 = en_cnt; r0 = rstp_cnt; x0 = err_cnt;
         send_word(vecs[i].w0, $sformatf("v%0d_w0", i), fc);
         send_word(vecs[i].w1, $sformatf("v%0d_w1", i), fc);
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d_en_pulses", i), en_cnt - e0, 1);
         chk($sformatf("v%0d_en_at_ack_fall", i), en_cyc, fc);
         chk($sformatf("v%0d_type", i), int'(cap_type), vecs[i].exp_type);
         chk($sformatf("v%0d_num", i), int'(cap_num), vecs[i].exp_num);
         chk($sformatf("v%0d_held_num", i), int'(interboard_number), vecs[i].exp_num);
         chk($sformatf("v%0d_irst_pulses", i), rstp_cnt - r0, vecs[i].exp_rst);
         if (vecs[i].exp_rst != 0) chk($sformatf("v%0d_irst_with_en", i), rstp_cyc, en_cyc);
         chk($sformatf("v%0d_no_err", i), err_cnt - x0, 0);
      end

      // word1 arriving with no word0 is acknowledged and discarded
      e0 = en_cnt; x0 = err_cnt;
      send_word(6'b1_00_011, "orphan_w1", fc);
      repeat (3) @(negedge clk);
      chk("orphan_err", err_cnt - x0, 1);
      chk("orphan_no_en", en_cnt - e0, 0);
      chk("orphan_busy", int'(rx_busy), 0);
      send_word(6'b0_011_01, "after_orphan_w0", fc);
      send_word(6'b1_00_110, "after_orphan_w1", fc);
      repeat (3) @(negedge clk);
      chk("after_orphan_en", en_cnt - e0, 1);
      chk("after_orphan_type", int'(cap_type), 3);
      chk("after_orphan_num", int'(cap_num), 14);

      // repeated word0 replaces the first one
      e0 = en_cnt; x0 = err_cnt;
      send_word(6'b0_010_11, "dup_w0a", fc);
      send_word(6'b0_001_00, "dup_w0b", fc);
      send_word(6'b1_00_111, "dup_w1", fc);
      repeat (3) @(negedge clk);
      chk("dup_err", err_cnt - x0, 1);
      chk("dup_en", en_cnt - e0, 1);
      chk("dup_type", int'(cap_type), 1);
      chk("dup_num", int'(cap_num), 7);

      // reset asserted while the receiver sits in ACK1
      e0 = en_cnt;
      send_word(6'b0_001_10, "rst_w0", fc);
      @(posedge clk); #1;
      Request_in    = 1'b1;
      inter_data_in = 6'b1_00_001;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (Ack_out) break;
      end
      chk("rst_ack1_reached", int'(Ack_out), 1);
      rst = 1'b0;
      #1;
      chk("rst_mid_ack", int'(Ack_out), 0);
      chk("rst_mid_en", int'(interboard_en), 0);
      chk("rst_mid_busy", int'(rx_busy), 0);
      chk("rst_mid_type", int'(interboard_msg_type), 0);
      chk("rst_mid_num", int'(interboard_number), 0);
      chk("rst_mid_err", int'(rx_error), 0);
      chk("rst_mid_irst", int'(interboard_rst), 0);
      Request_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_no_en", en_cnt - e0, 0);
      chk("rst_idle_busy", int'(rx_busy), 0);
      send_word(6'b0_011_00, "post_rst_w0", fc);
      send_word(6'b1_00_001, "post_rst_w1", fc);
      repeat (3) @(negedge clk);
      chk("post_rst_en", en_cnt - e0, 1);
      chk("post_rst_type", int'(cap_type), 3);
      chk("post_rst_num", int'(cap_num), 1);

`ifdef INTER_RX_TIMEOUT_EN
      // Ack falls one edge after WAIT1 is entered, so the timeout lands 99 later
      e0 = en_cnt; x0 = err_cnt;
      send_word(6'b0_010_10, "to_w0", fc);
      repeat (120) @(negedge clk);
      chk("to_err", err_cnt - x0, 1);
      chk("to_err_cycle", err_cyc, fc + 99);
      chk("to_busy", int'(rx_busy), 0);
      chk("to_no_en", en_cnt - e0, 0);
`else
      e0 = en_cnt; x0 = err_cnt;
      send_word(6'b0_010_10, "wait_w0", fc);
      repeat (150) @(negedge clk);
      chk("wait_busy", int'(rx_busy), 1);
      chk("wait_no_err", err_cnt - x0, 0);
      send_word(6'b1_00_011, "wait_w1", fc);
      repeat (3) @(negedge clk);
      chk("wait_en", en_cnt - e0, 1);
      chk("wait_type", int'(cap_type), 2);
      chk("wait_num", int'(cap_num), 19);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
`default_nettype wire
